// File: rtl/svf_pkg.sv
// Shared types for the SVF windowed sampler: default widths, sample record, FSM states.
package svf_pkg;

    localparam int unsigned SVF_W  = 20;
    localparam int unsigned INTV_W = 16;

    typedef struct packed {
        logic [INTV_W-1:0] idx;
        logic [SVF_W-1:0]  delta;
    } svf_sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } svf_smp_state_t;

endpackage

// File: rtl/svf_sampler_if.sv
// Sample stream from the SVF sampler to the trace/host consumer (valid/ready, show-ahead).
interface svf_sampler_if #(
    parameter int unsigned SVF_W  = svf_pkg::SVF_W,
    parameter int unsigned INTV_W = svf_pkg::INTV_W
) ();

    logic              sample_valid_o;
    logic [SVF_W-1:0]  sample_delta_o;
    logic [INTV_W-1:0] sample_idx_o;
    logic              sample_ready_i;

    modport master (
        output sample_valid_o,
        output sample_delta_o,
        output sample_idx_o,
        input  sample_ready_i
    );

    modport slave (
        input  sample_valid_o,
        input  sample_delta_o,
        input  sample_idx_o,
        output sample_ready_i
    );

endinterface

// File: rtl/svf_sample_fifo.sv
// Synchronous show-ahead FIFO; a push while full is accepted only when a pop frees a slot.
module svf_sample_fifo #(
    parameter type         T     = svf_pkg::svf_sample_t,
    parameter int unsigned DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  T     push_data_i,
    input  logic pop_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned     AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);

endmodule

// File: rtl/svf_sampler.sv
// Windowed sampler: every interval cycles, pushes {idx, total delta} into a show-ahead FIFO
// drained over valid/ready; overflowing samples are counted and still consume an idx.
module svf_sampler #(
    parameter int unsigned SVF_W      = svf_pkg::SVF_W,
    parameter int unsigned INTV_W     = svf_pkg::INTV_W,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DROP_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SVF_W-1:0]  total_svf_i,
    input  logic              enable_i,
    input  logic [INTV_W-1:0] interval_i,
    svf_sampler_if.master     smp,
    output logic [DROP_W-1:0] drop_cnt_o,
    output logic              busy_o
);

    import svf_pkg::*;

    // Width-parameterised mirror of svf_sample_t so overridden widths reach the FIFO.
    typedef struct packed {
        logic [INTV_W-1:0] idx;
        logic [SVF_W-1:0]  delta;
    } sample_t;

    localparam logic [INTV_W-1:0] ONE = INTV_W'(1);

    svf_smp_state_t    state_q, state_d;
    logic [SVF_W-1:0]  base_q, base_d;
    logic [INTV_W-1:0] intv_q, intv_d;
    logic [INTV_W-1:0] cnt_q, cnt_d;
    logic [INTV_W-1:0] idx_q, idx_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [INTV_W-1:0] intv_norm;
    logic              push, pop, full, empty;
    sample_t           push_data, head;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        intv_d    = intv_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        drop_d    = drop_q;
        push      = 1'b0;
        push_data = '0;
        intv_norm = (interval_i == '0) ? ONE : interval_i;
        pop       = !empty && smp.sample_ready_i;

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    base_d  = total_svf_i;
                    intv_d  = intv_norm;
                    cnt_d   = intv_norm;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (cnt_q == ONE) begin
                    push            = 1'b1;
                    push_data.idx   = idx_q;
                    push_data.delta = total_svf_i - base_q;
                    base_d          = total_svf_i;
                    cnt_d           = intv_q;
                    idx_d           = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push && full && !pop && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            intv_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            intv_q  <= intv_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
        end
    end

    svf_sample_fifo #(
        .T     (sample_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign smp.sample_valid_o = !empty;
    assign smp.sample_delta_o = head.delta;
    assign smp.sample_idx_o   = head.idx;
    assign drop_cnt_o         = drop_q;
    assign busy_o             = (state_q == RUN);

endmodule
